ysyx_23060096_wb_unit: RTL and testbench
========================================

// Module: ysyx_23060096_wb_unit
// PURPOSE
//  Write-back stage of the NPC core; sole writer of the GPR file write port (rf_wen/rf_waddr/rf_wdata).
//  Accepts one retiring instruction from EXU via valid/ready and waits for LSU read data on loads.
//  Sign/zero-extends load data, then commits: one-cycle register write plus commit pulse to IFU.
//  Strictly one instruction in flight; no overlap of accept and commit.
// PARAMETERS
//  XLEN     32  datapath / register width
//  REG_AW   5   register index width (32 GPRs, x0 hardwired zero)
// PORTS
//  clk          in   1       core clock, all state on posedge
//  rstn         in   1       asynchronous active-low reset
//  in_valid     in   1       EXU presents a retiring instruction
//  in_ready     out  1       WBU can accept (handshake = in_valid & in_ready)
//  in_rd        in   REG_AW  destination register index
//  in_rd_wen    in   1       instruction writes rd
//  in_result    in   XLEN    ALU/CSR/link result (ignored for loads)
//  in_is_load   in   1       instruction is a load; result comes from LSU
//  in_funct3    in   3       load size/sign: 000 LB,001 LH,010 LW,100 LBU,101 LHU
//  in_addr_lo   in   2       load byte address [1:0]
//  in_pc        in   XLEN    PC of retiring instruction
//  mem_rvalid   in   1       LSU read data valid
//  mem_rdata    in   XLEN    LSU read word (aligned 32-bit word)
//  mem_rready   out  1       WBU accepts read data
//  rf_wen       out  1       GPR write enable (one-cycle pulse)
//  rf_waddr     out  REG_AW  GPR write index
//  rf_wdata     out  XLEN    GPR write data
//  commit_valid out  1       instruction retired (one-cycle pulse)
//  commit_pc    out  XLEN    PC of retired instruction
// BEHAVIOUR
//  States: IDLE, WAIT_MEM, COMMIT (2-bit encoded). Reset -> IDLE.
//  Reset values: in_ready=1 (after reset release, IDLE), all other outputs 0; latched fields 0.
//  IDLE: in_ready=1, mem_rready=0. On handshake latch rd, rd_wen, result, funct3, addr_lo, pc.
//    !in_is_load -> COMMIT; in_is_load -> WAIT_MEM.
//  WAIT_MEM: in_ready=0, mem_rready=1. On mem_rvalid: extend and latch data -> COMMIT. Else stay.
//  COMMIT: in_ready=0, mem_rready=0. rf_wen=rd_wen & (rd!=0); rf_waddr=rd; rf_wdata=latched data;
//    commit_valid=1, commit_pc=pc. Unconditionally -> IDLE next cycle.
//  Latency: ALU op accepted at cycle T -> rf_wen/commit_valid at T+1; next accept at T+2.
//    Load: mem_rvalid at cycle M -> commit at M+1. Minimum load latency 2 cycles after accept.
//  in_ready and mem_rready are decoded from state only (no combinational path from in_valid/mem_rvalid).
//  Load extension: byte sel = addr_lo, half sel = addr_lo[1]; LB/LH sign-extend, LBU/LHU zero-extend,
//    LW passes word. Reserved funct3 (011,110,111) treated as LW. Misalignment not checked here.
//  x0: rf_wen never asserted for rd=0; commit_valid still pulses.
//  rd_wen=0 (branch/store): commit_valid pulses, rf_wen=0, rf_wdata don't-care but driven from latch.
//  mem_rvalid outside WAIT_MEM is ignored (not captured, no state change).
//  in_valid during WAIT_MEM/COMMIT: not accepted; EXU must hold inputs stable until handshake.
//  Reset mid-operation: pending instruction dropped, no write, no commit pulse; outputs 0 immediately.
//  rf_wen, rf_waddr, rf_wdata, commit_valid, commit_pc are registered-state derived, glitch-free.
// STRUCTURE
//  Package ysyx_23060096_pkg: XLEN, REG_AW, funct3 load constants (F3_LB..F3_LHU), wb state enum.
//  Sub-module ysyx_23060096_load_ext: combinational (word, addr_lo, funct3) -> extended XLEN data.
//  Top holds FSM, field latches, output decode.
// TESTING
//  1 ADD rd=5 result=0x0000_1234, in_valid at T -> T+1 rf_wen=1 waddr=5 wdata=0x1234, commit_valid=1, in_ready=0.
//  2 LB rd=6 addr_lo=3, mem_rdata=0x80FF_0000 after 3 stall cycles -> wdata=0xFFFF_FF80; LBU -> 0x0000_0080.
//  3 LH addr_lo=2, rdata=0x8001_7FFF -> 0xFFFF_8001; LHU addr_lo=0 -> 0x0000_7FFF; LW -> 0x8001_7FFF.
//  4 rd=0 result=0xDEAD_BEEF -> rf_wen=0, commit_valid=1; rd_wen=0 rd=7 -> rf_wen=0.
//  5 mem_rvalid pulsed in IDLE with 0x1111_1111, then load issued and rvalid 0x2222_2222 -> only 0x2222_2222 written.
//  6 rstn low during WAIT_MEM -> outputs 0 same cycle, no rf_wen; after release in_ready=1, new ALU op commits normally.

Source files
------------

// File: rtl/ysyx_23060096_pkg.sv
// Shared definitions for the NPC write-back unit.
//   XLEN / REG_AW : datapath and register-index widths
//   F3_*          : load funct3 encodings (size / signedness)
//   wb_state_e    : write-back FSM state encoding
//   wb_req_t      : instruction fields held while an instruction is in flight
package ysyx_23060096_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_MEM = 2'd1,
        S_COMMIT   = 2'd2
    } wb_state_e;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic              rd_wen;
        logic [2:0]        funct3;
        logic [1:0]        addr_lo;
        logic [XLEN-1:0]   pc;
    } wb_req_t;

endpackage

// File: rtl/ysyx_23060096_load_ext.sv
// Load data extraction / extension (purely combinational).
//   word    : aligned 32-bit word from LSU
//   addr_lo : byte offset of the access within the word
//   funct3  : load size/sign; reserved encodings behave as LW
//   data    : sign- or zero-extended result
module ysyx_23060096_load_ext
    import ysyx_23060096_pkg::*;
(
    input  logic [XLEN-1:0] word,
    input  logic [1:0]      addr_lo,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data
);

    logic [XLEN-1:0] shifted;
    logic [7:0]      byte_v;
    logic [15:0]     half_v;

    // Byte lane picked by the full offset, halfword lane by offset[1] only.
    assign shifted = word >> {addr_lo, 3'b000};
    assign byte_v  = shifted[7:0];
    assign half_v  = addr_lo[1] ? word[31:16] : word[15:0];

    always_comb begin
        data = word;
        case (funct3)
            F3_LB:   data = {{(XLEN-8){byte_v[7]}}, byte_v};
            F3_LH:   data = {{(XLEN-16){half_v[15]}}, half_v};
            F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_v};
            F3_LHU:  data = {{(XLEN-16){1'b0}}, half_v};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/ysyx_23060096_wb_unit.sv
// Write-back stage: sole writer of the GPR write port.
//   in_*     : retiring instruction from EXU (valid/ready handshake)
//   mem_*    : LSU read data for loads (valid/ready handshake)
//   rf_*     : one-cycle GPR write (never to x0)
//   commit_* : one-cycle retire pulse with the PC to IFU
// One instruction in flight: IDLE -> (WAIT_MEM) -> COMMIT -> IDLE.
module ysyx_23060096_wb_unit
    import ysyx_23060096_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_rd_wen,
    input  logic [XLEN-1:0]   in_result,
    input  logic              in_is_load,
    input  logic [2:0]        in_funct3,
    input  logic [1:0]        in_addr_lo,
    input  logic [XLEN-1:0]   in_pc,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              mem_rready,
    output logic              rf_wen,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [XLEN-1:0]   rf_wdata,
    output logic              commit_valid,
    output logic [XLEN-1:0]   commit_pc
);

    wb_state_e       state, state_nxt;
    wb_req_t         req;
    logic [XLEN-1:0] data;
    logic [XLEN-1:0] ext_data;
    logic            accept;
    logic            mem_fire;

    ysyx_23060096_load_ext u_load_ext (
        .word    (mem_rdata),
        .addr_lo (req.addr_lo),
        .funct3  (req.funct3),
        .data    (ext_data)
    );

    assign accept   = in_valid & in_ready;
    assign mem_fire = mem_rvalid & mem_rready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
            req   <= '0;
            data  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                req.rd      <= in_rd;
                req.rd_wen  <= in_rd_wen;
                req.funct3  <= in_funct3;
                req.addr_lo <= in_addr_lo;
                req.pc      <= in_pc;
                // For loads this is overwritten when the LSU data arrives.
                data        <= in_result;
            end else if (mem_fire) begin
                data <= ext_data;
            end
        end
    end

    // Handshake readies and all commit outputs depend on state and latched
    // fields only, so nothing combinational leaks from in_valid/mem_rvalid.
    always_comb begin
        state_nxt    = state;
        in_ready     = 1'b0;
        mem_rready   = 1'b0;
        rf_wen       = 1'b0;
        rf_waddr     = '0;
        rf_wdata     = '0;
        commit_valid = 1'b0;
        commit_pc    = '0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = in_is_load ? S_WAIT_MEM : S_COMMIT;
            end
            S_WAIT_MEM: begin
                mem_rready = 1'b1;
                if (mem_rvalid) state_nxt = S_COMMIT;
            end
            S_COMMIT: begin
                rf_wen       = req.rd_wen & (req.rd != '0);
                rf_waddr     = req.rd;
                rf_wdata     = data;
                commit_valid = 1'b1;
                commit_pc    = req.pc;
                state_nxt    = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ysyx_23060096_wb_unit.sv
module tb_ysyx_23060096_wb_unit;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic        in_rd_wen;
    logic [31:0] in_result;
    logic        in_is_load;
    logic [2:0]  in_funct3;
    logic [1:0]  in_addr_lo;
    logic [31:0] in_pc;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        mem_rready;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        commit_valid;
    logic [31:0] commit_pc;

    int checks   = 0;
    int failures = 0;

    ysyx_23060096_wb_unit dut (
        .clk          (clk),
        .rstn         (rstn),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_rd        (in_rd),
        .in_rd_wen    (in_rd_wen),
        .in_result    (in_result),
        .in_is_load   (in_is_load),
        .in_funct3    (in_funct3),
        .in_addr_lo   (in_addr_lo),
        .in_pc        (in_pc),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .mem_rready   (mem_rready),
        .rf_wen       (rf_wen),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .commit_valid (commit_valid),
        .commit_pc    (commit_pc)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference load result, computed arithmetically from the ISA rules.
    function automatic logic [31:0] ref_ext(input logic [31:0] w, input logic [1:0] a,
                                            input logic [2:0] f3);
        logic [31:0] b, h;
        b = (w >> (8 * int'(a))) & 32'hFF;
        h = (w >> (16 * (int'(a) / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
            3'd1:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    // Issues one instruction starting just after a clock edge with the unit idle,
    // checks the commit cycle and the return to idle.
    task automatic run_op(input string tag, input bit is_load, input logic [4:0] rd,
                          input bit wen, input logic [31:0] result, input logic [2:0] f3,
                          input logic [1:0] alo, input logic [31:0] pc, input int stall,
                          input logic [31:0] rdata);
        logic [31:0] exp_data;
        chk({tag, ":in_ready_idle"}, in_ready, 1);
        in_valid   = 1'b1;
        in_rd      = rd;
        in_rd_wen  = wen;
        in_result  = result;
        in_is_load = is_load;
        in_funct3  = f3;
        in_addr_lo = alo;
        in_pc      = pc;
        @(posedge clk); #1;
        // Scramble inputs so that anything not latched at the handshake shows up.
        in_valid   = 1'b0;
        in_rd      = 5'($urandom);
        in_rd_wen  = 1'($urandom);
        in_result  = $urandom;
        in_is_load = 1'($urandom);
        in_funct3  = 3'($urandom);
        in_addr_lo = 2'($urandom);
        in_pc      = $urandom;
        if (is_load) begin
            exp_data = ref_ext(rdata, alo, f3);
            chk({tag, ":mem_rready"}, mem_rready, 1);
            chk({tag, ":in_ready_wait"}, in_ready, 0);
            for (int s = 0; s < stall; s++) begin
                mem_rvalid = 1'b0;
                mem_rdata  = $urandom;
                @(posedge clk); #1;
                chk({tag, ":stall_no_commit"}, commit_valid, 0);
            end
            mem_rvalid = 1'b1;
            mem_rdata  = rdata;
            @(posedge clk); #1;
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
        end else begin
            exp_data = result;
        end
        chk({tag, ":commit_valid"}, commit_valid, 1);
        chk({tag, ":rf_wen"}, rf_wen, (wen && rd != 5'd0) ? 1 : 0);
        chk({tag, ":rf_waddr"}, rf_waddr, rd);
        chk({tag, ":rf_wdata"}, rf_wdata, exp_data);
        chk({tag, ":commit_pc"}, commit_pc, pc);
        chk({tag, ":in_ready_commit"}, in_ready, 0);
        chk({tag, ":mem_rready_commit"}, mem_rready, 0);
        // Stray read data during commit must be ignored.
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h5A5A_5A5A;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        chk({tag, ":commit_pulse_end"}, commit_valid, 0);
        chk({tag, ":rf_wen_pulse_end"}, rf_wen, 0);
    endtask

    initial begin
        rstn       = 1'b0;
        in_valid   = 1'b0;
        in_rd      = '0;
        in_rd_wen  = 1'b0;
        in_result  = '0;
        in_is_load = 1'b0;
        in_funct3  = '0;
        in_addr_lo = '0;
        in_pc      = '0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst:in_ready", in_ready, 1);
        chk("rst:mem_rready", mem_rready, 0);
        chk("rst:rf_wen", rf_wen, 0);
        chk("rst:rf_waddr", rf_waddr, 0);
        chk("rst:rf_wdata", rf_wdata, 0);
        chk("rst:commit_valid", commit_valid, 0);
        chk("rst:commit_pc", commit_pc, 0);
        rstn = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        run_op("add",  0, 5'd5, 1, 32'h0000_1234, 3'd0, 2'd0, 32'h8000_0000, 0, 32'h0);
        run_op("lb",   1, 5'd6, 1, 32'h0, 3'b000, 2'd3, 32'h8000_0004, 3, 32'h80FF_0000);
        run_op("lbu",  1, 5'd6, 1, 32'h0, 3'b100, 2'd3, 32'h8000_0008, 1, 32'h80FF_0000);
        run_op("lh",   1, 5'd7, 1, 32'h0, 3'b001, 2'd2, 32'h8000_000C, 0, 32'h8001_7FFF);
        run_op("lhu",  1, 5'd7, 1, 32'h0, 3'b101, 2'd0, 32'h8000_0010, 2, 32'h8001_7FFF);
        run_op("lw",   1, 5'd8, 1, 32'h0, 3'b010, 2'd0, 32'h8000_0014, 0, 32'h8001_7FFF);
        run_op("lres", 1, 5'd8, 1, 32'h0, 3'b111, 2'd1, 32'h8000_0018, 1, 32'hCAFE_F00D);
        run_op("x0",   0, 5'd0, 1, 32'hDEAD_BEEF, 3'd0, 2'd0, 32'h8000_001C, 0, 32'h0);
        run_op("nowen",0, 5'd7, 0, 32'h0000_00AA, 3'd0, 2'd0, 32'h8000_0020, 0, 32'h0);

        // Read data presented while idle must not be captured.
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1111_1111;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        chk("idle_rvalid:commit", commit_valid, 0);
        chk("idle_rvalid:in_ready", in_ready, 1);
        run_op("ld_after_stray", 1, 5'd10, 1, 32'h0, 3'b010, 2'd0, 32'h8000_0024, 1, 32'h2222_2222);

        // Reset while waiting for load data drops the instruction.
        in_valid   = 1'b1;
        in_rd      = 5'd9;
        in_rd_wen  = 1'b1;
        in_is_load = 1'b1;
        in_funct3  = 3'b010;
        in_pc      = 32'h8000_0100;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("rst_mid:wait_mem", mem_rready, 1);
        #2 rstn = 1'b0;
        #1;
        chk("rst_mid:rf_wen", rf_wen, 0);
        chk("rst_mid:commit", commit_valid, 0);
        chk("rst_mid:mem_rready", mem_rready, 0);
        chk("rst_mid:commit_pc", commit_pc, 0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h3333_3333;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        chk("rst_mid:no_commit_in_rst", commit_valid, 0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid:in_ready_after", in_ready, 1);
        chk("rst_mid:no_commit_after", commit_valid, 0);
        run_op("post_rst_add", 0, 5'd11, 1, 32'h0BAD_F00D, 3'd0, 2'd0, 32'h8000_0200, 0, 32'h0);

        // Randomized instruction stream
        for (int i = 0; i < 60; i++) begin
            run_op($sformatf("rand%0d", i), 1'($urandom), 5'($urandom_range(0, 31)),
                   1'($urandom), $urandom, 3'($urandom), 2'($urandom), $urandom,
                   int'($urandom_range(0, 3)), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
